regfile_read_port_array: RTL and testbench
==========================================

// Module: regfile_read_port_array
// PURPOSE
//   Parametrised multi-port register-file read block: NREAD independent read ports, each selecting
//   one WIDTH-bit entry from a flattened DEPTH-entry register array, with registered output.
//   Adds write-bypass, an optional hardwired zero register, a selectable 1- or 2-stage output pipe,
//   per-port valid and a sticky out-of-range address error. Sits between the register array and
//   the operand-fetch stage of the core.
// PARAMETERS
//   WIDTH     32  data width of one register entry
//   DEPTH     32  number of entries (need not be a power of two; >=2)
//   NREAD      2  number of read ports (1..4)
//   PIPE       1  output pipeline depth, 1 or 2 (other values illegal)
//   ZERO_REG   1  1: entry 0 always reads as 0 (bypass to entry 0 ignored); 0: entry 0 is normal
//   AW (localparam) = $clog2(DEPTH)
// PORTS
//   clk       in   1              clock, all logic on rising edge
//   rst_n     in   1              synchronous reset, active low
//   regs_in   in   WIDTH*DEPTH    flattened array; entry k = regs_in[k*WIDTH +: WIDTH]
//   wr_en     in   1              write to the array is occurring this cycle
//   wr_addr   in   AW             write entry index
//   wr_data   in   WIDTH          write data (becomes visible in regs_in next cycle)
//   rd_en     in   NREAD          per-port read request
//   rd_addr   in   NREAD*AW       port p address = rd_addr[p*AW +: AW]
//   rd_data   out  NREAD*WIDTH    port p data = rd_data[p*WIDTH +: WIDTH]
//   rd_valid  out  NREAD          port p rd_data carries a new result
//   addr_err  out  1              sticky: some enabled read used rd_addr >= DEPTH
//   err_clr   in   1              clears addr_err
// BEHAVIOUR
//   - Reset (rst_n=0 at rising edge): rd_data=0, rd_valid=0, addr_err=0, all pipe regs cleared;
//     reset mid-operation discards in-flight reads (no valid emitted for them).
//   - Stage-1 select per port, evaluated in the cycle rd_en[p]=1:
//       addr>=DEPTH -> 0; else ZERO_REG && addr==0 -> 0;
//       else wr_en && wr_addr==addr -> wr_data (bypass); else entry[addr].
//   - PIPE=1: selected value registered into rd_data on the edge; rd_valid[p]=1 the next cycle.
//     Latency 1 clock.
//   - PIPE=2: stage-1 reg holds {value, addr, valid}; stage-2 copies it to rd_data/rd_valid next edge.
//     At stage-2 transfer, if wr_en && wr_addr==latched addr (and not the zero-reg/out-of-range case),
//     wr_data replaces the latched value. Latency 2 clocks; one request per port per cycle accepted.
//   - rd_en[p]=0: that port's valid bit in the affected stage goes 0; rd_data[p] holds its last value.
//   - Ports fully independent; several ports may read the same address and same-cycle bypass applies
//     to all of them.
//   - addr_err set on the edge after any enabled port presents addr>=DEPTH (only possible when DEPTH
//     not a power of two); stays set until err_clr=1; simultaneous set and clear -> stays set.
//   - Disabled ports never set addr_err; write with wr_addr>=DEPTH has no bypass effect.
//   - No combinational path from inputs to outputs.
// TESTING
//   1. DEPTH=32,PIPE=1: entry 5=0xDEADBEEF, rd_en[0]=1 addr 5 -> next cycle rd_data[0]=0xDEADBEEF,
//      rd_valid[0]=1; following cycle rd_en=0 -> rd_valid[0]=0, data held.
//   2. Bypass: entry 7=0x11, same cycle wr_en=1 wr_addr=7 wr_data=0x22, read 7 on ports 0,1 ->
//      both return 0x22. PIPE=2 with write arriving one cycle after request -> also 0x22.
//   3. ZERO_REG=1: entry 0=0xFFFFFFFF, wr to 0 with 0x5 same cycle, read 0 -> 0x0; ZERO_REG=0 -> 0x5.
//   4. DEPTH=24: read addr 30 -> rd_data=0, rd_valid=1, addr_err=1 next cycle; err_clr with no new
//      error -> 0; err_clr same cycle as new bad read -> addr_err stays 1.
//   5. PIPE=2 back-to-back reads of addrs 1,2,3 on consecutive cycles -> data appear cycles 2,3,4,
//      rd_valid continuous.
//   6. rst_n=0 while PIPE=2 read in flight -> next cycles rd_valid=0, rd_data=0, addr_err=0.

Source files
------------

// File: rtl/regfile_read_port_array.sv
// Multi-port register-file read block: per-port select with write bypass, optional zero
// register, 1- or 2-stage registered output, per-port valid and a sticky bad-address flag.
module regfile_read_port_array #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int PIPE     = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*DEPTH-1:0] regs_in,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [NREAD-1:0]       rd_en,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_valid,
    output logic                   addr_err,
    input  logic                   err_clr
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] sel [NREAD];
    logic [AW-1:0]    ra  [NREAD];
    logic [NREAD-1:0] oor;
    logic [NREAD-1:0] zsel;
    logic             err_set;

    // Stage-1 select: out-of-range and zero-register reads are forced to 0 and never bypassed.
    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            ra[p]   = rd_addr[p*AW +: AW];
            oor[p]  = ({1'b0, ra[p]} >= DEPTH_L);
            zsel[p] = (ZERO_REG != 0) && (ra[p] == '0);
            if (oor[p] || zsel[p]) begin
                sel[p] = '0;
            end else if (wr_en && (wr_addr == ra[p])) begin
                sel[p] = wr_data;
            end else begin
                sel[p] = regs_in[int'(ra[p])*WIDTH +: WIDTH];
            end
        end
    end

    assign err_set = |(rd_en & oor);

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (err_set) begin
            addr_err <= 1'b1;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end
    end

    if (PIPE == 2) begin : g_pipe2
        logic [WIDTH-1:0] s1_data [NREAD];
        logic [AW-1:0]    s1_addr [NREAD];
        logic [NREAD-1:0] s1_vld;
        logic [NREAD-1:0] s1_fix;

        // s1_fix marks values pinned to 0 that a later write must not replace.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int p = 0; p < NREAD; p++) begin
                    s1_data[p] <= '0;
                    s1_addr[p] <= '0;
                end
                s1_vld   <= '0;
                s1_fix   <= '0;
                rd_valid <= '0;
                rd_data  <= '0;
            end else begin
                s1_vld   <= rd_en;
                rd_valid <= s1_vld;
                for (int p = 0; p < NREAD; p++) begin
                    if (rd_en[p]) begin
                        s1_data[p] <= sel[p];
                        s1_addr[p] <= ra[p];
                        s1_fix[p]  <= oor[p] | zsel[p];
                    end
                    if (s1_vld[p]) begin
                        if (wr_en && !s1_fix[p] && (wr_addr == s1_addr[p])) begin
                            rd_data[p*WIDTH +: WIDTH] <= wr_data;
                        end else begin
                            rd_data[p*WIDTH +: WIDTH] <= s1_data[p];
                        end
                    end
                end
            end
        end
    end else begin : g_pipe1
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_valid <= '0;
                rd_data  <= '0;
            end else begin
                rd_valid <= rd_en;
                for (int p = 0; p < NREAD; p++) begin
                    if (rd_en[p]) begin
                        rd_data[p*WIDTH +: WIDTH] <= sel[p];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_port_array.sv
// Bench for regfile_read_port_array: three instances (PIPE=1/zero-reg, PIPE=2/no zero-reg,
// PIPE=2/zero-reg) share stimulus and are checked against an architectural register model.
module tb_regfile_read_port_array;

    localparam int W  = 32;
    localparam int D  = 24;
    localparam int N  = 2;
    localparam int AW = 5;
    localparam int ND = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W*D-1:0]   regs_in;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic [N-1:0]     rd_en;
    logic [N*AW-1:0]  rd_addr;
    logic             err_clr;

    logic [N*W-1:0]   got_data [ND];
    logic [N-1:0]     got_vld  [ND];
    logic             got_err  [ND];

    always #5 clk = ~clk;

    regfile_read_port_array #(.WIDTH(W), .DEPTH(D), .NREAD(N), .PIPE(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .regs_in(regs_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(got_data[0]),
        .rd_valid(got_vld[0]), .addr_err(got_err[0]), .err_clr(err_clr));

    regfile_read_port_array #(.WIDTH(W), .DEPTH(D), .NREAD(N), .PIPE(2), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .regs_in(regs_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(got_data[1]),
        .rd_valid(got_vld[1]), .addr_err(got_err[1]), .err_clr(err_clr));

    regfile_read_port_array #(.WIDTH(W), .DEPTH(D), .NREAD(N), .PIPE(2), .ZERO_REG(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .regs_in(regs_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(got_data[2]),
        .rd_valid(got_vld[2]), .addr_err(got_err[2]), .err_clr(err_clr));

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  mem      [D];
    logic [W-1:0]  exp_data [ND][N];
    logic          exp_vld  [ND][N];
    logic          exp_err;
    logic [N-1:0]  prev_en;
    logic [AW-1:0] prev_addr [N];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Architectural value of an entry: the model array already holds every write made so far.
    function automatic logic [W-1:0] arch_val(input logic [AW-1:0] a, input bit zero);
        if (int'(a) >= D) return '0;
        if (zero && a == '0) return '0;
        return mem[a];
    endfunction

    task automatic step(input bit rst, input logic [N-1:0] en, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input bit we, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input bit clr);
        logic [AW-1:0] a [N];
        bit bad;
        a[0] = a0;
        a[1] = a1;
        rst_n   = rst;
        rd_en   = en;
        rd_addr = {a1, a0};
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        err_clr = clr;
        for (int k = 0; k < D; k++) regs_in[k*W +: W] = mem[k];
        if (we && int'(wa) < D) mem[wa] = wd;

        if (!rst) begin
            for (int i = 0; i < ND; i++)
                for (int p = 0; p < N; p++) begin
                    exp_data[i][p] = '0;
                    exp_vld[i][p]  = 1'b0;
                end
            exp_err = 1'b0;
            prev_en = '0;
        end else begin
            bad = 1'b0;
            for (int p = 0; p < N; p++) begin
                // PIPE=1 sees writes up to this cycle; PIPE=2 sees writes up to one cycle later.
                exp_vld[0][p] = en[p];
                if (en[p]) exp_data[0][p] = arch_val(a[p], 1'b1);
                for (int i = 1; i < ND; i++) begin
                    exp_vld[i][p] = prev_en[p];
                    if (prev_en[p]) exp_data[i][p] = arch_val(prev_addr[p], i == 2);
                end
                if (en[p] && int'(a[p]) >= D) bad = 1'b1;
            end
            if (bad) exp_err = 1'b1;
            else if (clr) exp_err = 1'b0;
            prev_en = en;
            for (int p = 0; p < N; p++) prev_addr[p] = a[p];
        end

        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            for (int p = 0; p < N; p++) begin
                check($sformatf("dut%0d_data%0d", i, p), got_data[i][p*W +: W], exp_data[i][p]);
                check($sformatf("dut%0d_valid%0d", i, p), W'(got_vld[i][p]), W'(exp_vld[i][p]));
            end
            check($sformatf("dut%0d_addr_err", i), W'(got_err[i]), W'(exp_err));
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom_range(D, 31));
        return AW'($urandom_range(0, D-1));
    endfunction

    initial begin
        logic [AW-1:0] ra0, ra1, rwa;
        for (int k = 0; k < D; k++) mem[k] = $urandom;
        mem[0] = 32'hFFFF_FFFF;
        mem[5] = 32'hDEAD_BEEF;
        mem[7] = 32'h0000_0011;
        rst_n = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; err_clr = 1'b0; regs_in = '0;

        step(0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0);

        // single read then idle: data held, valid drops
        step(1, 2'b01, 5, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0);
        // same-cycle bypass on both ports
        step(1, 2'b11, 7, 7, 1, 7, 32'h22, 0);
        step(1, 2'b00, 0, 0, 1, 7, 32'h11, 0);
        // write one cycle after the request
        step(1, 2'b11, 7, 7, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 1, 7, 32'h22, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0);
        // zero register with same-cycle write to entry 0
        step(1, 2'b11, 0, 0, 1, 0, 32'h5, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0);
        // out-of-range read, clear, clear racing a new error, disabled bad address
        step(1, 2'b01, 30, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 1);
        step(1, 2'b01, 30, 0, 0, 0, 0, 1);
        step(1, 2'b01, 3, 31, 1, 28, 32'h99, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 1);
        // back-to-back reads
        step(1, 2'b01, 1, 0, 0, 0, 0, 0);
        step(1, 2'b01, 2, 0, 0, 0, 0, 0);
        step(1, 2'b01, 3, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0);
        // reset with reads in flight
        step(1, 2'b11, 30, 9, 0, 0, 0, 0);
        step(0, 2'b11, 4, 6, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            ra0 = pick_addr();
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : pick_addr();
            rwa = ($urandom_range(0, 1) == 0) ? ra0 : AW'($urandom_range(0, 31));
            step($urandom_range(0, 49) != 0, N'($urandom), ra0, ra1,
                 $urandom_range(0, 1) == 1, rwa, $urandom, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
